wb_encoder_velocity_slave: RTL and testbench
============================================

Name: wb_encoder_velocity_slave

Overview:
- Pipelined Wishbone slave that receives the 32-bit encoder velocity. The encoder bus master writes it as two 16-bit halves: low half to 0x400E, high half to 0x400F.
- Pairs the halves, publishes the word to the DSP control loop over a valid/ready port, and answers reads of the last published value.
- Sits on the shared Wishbone bus as the responder for the encoder master's write bursts.

Parameters:
- WISHBONE_DATAWIDTH, 15, MSB index of data buses (16-bit data).
- WISHBONE_ADDRESSWIDTH, 15, MSB index of address bus (16-bit address).
- LO_ADDR, 16'h400E, address of the low half-word; high half is LO_ADDR+1.

Ports:
- CLK_I  in  1  system clock, all logic on rising edge.
- RST_I  in  1  asynchronous, active-low reset.
- CYC_I  in  1  Wishbone cycle.
- STB_I  in  1  Wishbone strobe.
- WE_I  in  1  1 = write, 0 = read.
- ADR_I  in  16  Wishbone address.
- DAT_I  in  16  write data.
- DAT_O  out  16  read data, valid only with ACK_O.
- ACK_O  out  1  one-cycle acknowledge per accepted request.
- STALL_O  out  1  request queue full.
- velocity  out  32  last committed {high, low} word.
- velocity_valid  out  1  new word available.
- velocity_ready  in  1  consumer takes word.
- orphan_hi  out  1  sticky: a high write committed without a fresh low half.

Behaviour:
- Reset (RST_I low, asynchronous): queue empty; ACK_O=0, STALL_O=0, DAT_O=0; velocity=0, velocity_valid=0; lo_latch=0, lo_pending=0, orphan_hi=0.
- Accept: request accepted at an edge when CYC_I & STB_I & ~STALL_O. {WE_I, ADR_I, DAT_I} is pushed into a 2-entry FIFO.
- STALL_O: equals (count==2). Driven from registers only, with no combinational path from STB_I.
- Head processing: each edge with a non-empty queue and CYC_I high, the head is examined.
- Write to LO_ADDR: lo_latch<=DAT, lo_pending<=1, pop.
- Write to LO_ADDR+1, not blocked:
  - velocity<={DAT, lo_latch}, velocity_valid<=1, lo_pending<=0, pop.
  - If lo_pending was 0, orphan_hi<=1 (stale lo_latch is still used).
- Blocked: a high write is blocked while velocity_valid & ~velocity_ready. The head stays, no ACK is issued, and the queue may fill and raise STALL_O.
- Write to any other address: ignored, popped, acked.
- Read at LO_ADDR returns velocity[15:0]; read at LO_ADDR+1 returns velocity[31:16]; read at any other address returns 0. Each read pops.
- ACK_O and DAT_O are registered: for the head popped at edge k, ACK_O=1 (and DAT_O = read data for reads, 0 for writes) during the cycle after edge k.
- Otherwise ACK_O=0 and DAT_O=0.
- Throughput: one pop per clock.
- Latency: request accepted at edge n is popped at edge n+1 when unblocked, so the master samples ACK_O at edge n+2.
- Consumer handshake: velocity_valid clears on an edge with velocity_ready & velocity_valid.
  - If a high write commits on the same edge, velocity_valid stays 1 and velocity takes the new value.
  - Commit has priority over clear.
- Simultaneous push and pop: allowed, count unchanged. A push is impossible when count==2.
- CYC_I low:
  - Queue is flushed at the next edge, with no pops and no ACKs.
  - ACK_O is forced 0 on that edge.
  - lo_latch, lo_pending, velocity and velocity_valid are retained.
- Reset mid-operation: immediate return to the reset state. Pending requests are lost and are never acked.
- orphan_hi clears only on reset.
- Pointers wrap modulo 2; the count is 2 bits.

Test Plan:
- Burst write 0x400E=0x1234 then 0x400F=0xABCD on back-to-back strobes, velocity_ready=1 → ACK_O on 2 consecutive cycles starting 2 edges after the first accept; velocity=0xABCD1234, velocity_valid one cycle; orphan_hi=0.
- velocity_ready=0 with velocity_valid=1, then write the pair 0x0001/0x0002, followed by a third strobe → low acked; high blocked; queue holds high+third, STALL_O=1 asserts; raise velocity_ready → high commits (velocity=0x00020001), ACK follows, STALL_O drops next cycle.
- Write 0x400F=0x5555 with no preceding low write after reset → velocity=0x55550000, orphan_hi=1, ACK_O issued.
- Read 0x400E, 0x400F, 0x4010 after velocity=0xABCD1234 → three ACKs with DAT_O=0x1234, 0xABCD, 0x0000; DAT_O=0 when ACK_O=0.
- Accept 2 writes, drop CYC_I before either pops → no ACKs; queue empty; lo_pending unchanged; STALL_O=0.
- Assert RST_I low mid-burst, asynchronously between edges → all outputs 0 immediately; no ACK after release until a new request is accepted.

Source files
------------

// File: rtl/wb_encoder_velocity_slave.sv
// Wishbone slave pairing two 16-bit encoder velocity halves into one 32-bit word
// and publishing it to the DSP loop over a valid/ready port.
module wb_encoder_velocity_slave #(
  parameter int WISHBONE_DATAWIDTH = 15,
  parameter int WISHBONE_ADDRESSWIDTH = 15,
  parameter logic [WISHBONE_ADDRESSWIDTH:0] LO_ADDR = 16'h400E
) (
  input  logic                              CLK_I,
  input  logic                              RST_I,
  input  logic                              CYC_I,
  input  logic                              STB_I,
  input  logic                              WE_I,
  input  logic [WISHBONE_ADDRESSWIDTH:0]    ADR_I,
  input  logic [WISHBONE_DATAWIDTH:0]       DAT_I,
  output logic [WISHBONE_DATAWIDTH:0]       DAT_O,
  output logic                              ACK_O,
  output logic                              STALL_O,
  output logic [2*WISHBONE_DATAWIDTH+1:0]   velocity,
  output logic                              velocity_valid,
  input  logic                              velocity_ready,
  output logic                              orphan_hi
);

  localparam int DW = WISHBONE_DATAWIDTH + 1;
  localparam int AW = WISHBONE_ADDRESSWIDTH + 1;
  localparam logic [AW-1:0] HI_ADDR = LO_ADDR + 1'b1;

  typedef struct packed {
    logic          we;
    logic [AW-1:0] adr;
    logic [DW-1:0] dat;
  } req_t;

  req_t            fifo_q [2];
  logic            wr_ptr_q;
  logic            rd_ptr_q;
  logic [1:0]      count_q;
  logic            ack_q;
  logic [DW-1:0]   dat_q;
  logic [2*DW-1:0] vel_q;
  logic            vel_valid_q;
  logic [DW-1:0]   lo_latch_q;
  logic            lo_pending_q;
  logic            orphan_q;

  req_t            head;
  logic            full;
  logic            push;
  logic            head_vld;
  logic            is_lo;
  logic            is_hi;
  logic            blocked;
  logic            pop;
  logic            commit;
  logic            lo_wr;
  logic            rd_lo;
  logic            rd_hi;
  logic [DW-1:0]   rd_data;

  assign full     = (count_q == 2'd2);
  assign push     = CYC_I & STB_I & ~full;
  assign head     = fifo_q[rd_ptr_q];
  assign head_vld = CYC_I & (count_q != 2'd0);
  assign is_lo    = (head.adr == LO_ADDR);
  assign is_hi    = (head.adr == HI_ADDR);

  // A high write must not overwrite a word the consumer has not taken yet
  assign blocked  = head.we & is_hi & vel_valid_q & ~velocity_ready;
  assign pop      = head_vld & ~blocked;
  assign commit   = pop & head.we & is_hi;
  assign lo_wr    = pop & head.we & is_lo;
  assign rd_lo    = ~head.we & is_lo;
  assign rd_hi    = ~head.we & is_hi;

  always_comb begin
    rd_data = '0;
    unique case (1'b1)
      rd_lo:   rd_data = vel_q[DW-1:0];
      rd_hi:   rd_data = vel_q[2*DW-1:DW];
      default: rd_data = '0;
    endcase
  end

  always_ff @(posedge CLK_I or negedge RST_I) begin
    if (!RST_I) begin
      fifo_q[0]    <= '0;
      fifo_q[1]    <= '0;
      wr_ptr_q     <= 1'b0;
      rd_ptr_q     <= 1'b0;
      count_q      <= 2'd0;
      ack_q        <= 1'b0;
      dat_q        <= '0;
      vel_q        <= '0;
      vel_valid_q  <= 1'b0;
      lo_latch_q   <= '0;
      lo_pending_q <= 1'b0;
      orphan_q     <= 1'b0;
    end else begin
      if (!CYC_I) begin
        wr_ptr_q <= 1'b0;
        rd_ptr_q <= 1'b0;
        count_q  <= 2'd0;
        ack_q    <= 1'b0;
        dat_q    <= '0;
      end else begin
        if (push) begin
          fifo_q[wr_ptr_q] <= '{we: WE_I, adr: ADR_I, dat: DAT_I};
          wr_ptr_q         <= ~wr_ptr_q;
        end
        if (pop) begin
          rd_ptr_q <= ~rd_ptr_q;
        end
        count_q <= count_q + 2'(push) - 2'(pop);
        ack_q   <= pop;
        dat_q   <= pop ? rd_data : '0;
      end

      if (lo_wr) begin
        lo_latch_q   <= head.dat;
        lo_pending_q <= 1'b1;
      end else if (commit) begin
        lo_pending_q <= 1'b0;
      end

      // Commit wins over the consumer clearing valid on the same edge
      if (commit) begin
        vel_q       <= {head.dat, lo_latch_q};
        vel_valid_q <= 1'b1;
        if (!lo_pending_q) begin
          orphan_q <= 1'b1;
        end
      end else if (vel_valid_q & velocity_ready) begin
        vel_valid_q <= 1'b0;
      end
    end
  end

  assign ACK_O          = ack_q;
  assign DAT_O          = dat_q;
  assign STALL_O        = full;
  assign velocity       = vel_q;
  assign velocity_valid = vel_valid_q;
  assign orphan_hi      = orphan_q;

endmodule

// File: tb/tb_wb_encoder_velocity_slave.sv
// Scoreboard bench for wb_encoder_velocity_slave: expected ack data is queued
// when a request is driven and compared whenever the slave acknowledges.
module tb_wb_encoder_velocity_slave;

  logic        CLK_I = 1'b0;
  logic        RST_I = 1'b0;
  logic        CYC_I = 1'b0;
  logic        STB_I = 1'b0;
  logic        WE_I  = 1'b0;
  logic [15:0] ADR_I = '0;
  logic [15:0] DAT_I = '0;
  logic        velocity_ready = 1'b0;
  logic [15:0] DAT_O;
  logic        ACK_O;
  logic        STALL_O;
  logic [31:0] velocity;
  logic        velocity_valid;
  logic        orphan_hi;

  int passed = 0;
  int total  = 0;
  logic [15:0] sb [$];
  logic [15:0] exp_dat;

  wb_encoder_velocity_slave dut (
    .CLK_I          (CLK_I),
    .RST_I          (RST_I),
    .CYC_I          (CYC_I),
    .STB_I          (STB_I),
    .WE_I           (WE_I),
    .ADR_I          (ADR_I),
    .DAT_I          (DAT_I),
    .DAT_O          (DAT_O),
    .ACK_O          (ACK_O),
    .STALL_O        (STALL_O),
    .velocity       (velocity),
    .velocity_valid (velocity_valid),
    .velocity_ready (velocity_ready),
    .orphan_hi      (orphan_hi)
  );

  always #5 CLK_I = ~CLK_I;

  always @(negedge CLK_I) begin
    if (RST_I && ACK_O) begin
      total++;
      if (sb.size() == 0) begin
        $display("FAIL unexpected_ack: got ack DAT_O=%h, want no ack", DAT_O);
      end else begin
        exp_dat = sb.pop_front();
        if (DAT_O !== exp_dat)
          $display("FAIL ack_data: got %h want %h", DAT_O, exp_dat);
        else passed++;
      end
    end
  end

  task automatic tick();
    @(posedge CLK_I);
    #1;
  endtask

  task automatic req(input logic we, input logic [15:0] a, input logic [15:0] d);
    CYC_I = 1'b1;
    STB_I = 1'b1;
    WE_I  = we;
    ADR_I = a;
    DAT_I = d;
  endtask

  task automatic test_reset();
    RST_I = 1'b0;
    tick();
    tick();
    total++;
    if ({ACK_O, STALL_O, velocity_valid, orphan_hi} !== 4'b0)
      $display("FAIL reset_flags: got %b want 0000",
               {ACK_O, STALL_O, velocity_valid, orphan_hi});
    else passed++;
    total++;
    if (DAT_O !== 16'h0) $display("FAIL reset_dat: got %h want 0", DAT_O);
    else passed++;
    total++;
    if (velocity !== 32'h0) $display("FAIL reset_vel: got %h want 0", velocity);
    else passed++;
    RST_I = 1'b1;
    tick();
  endtask

  task automatic test_burst();
    velocity_ready = 1'b1;
    req(1'b1, 16'h400E, 16'h1234); sb.push_back(16'h0);
    tick();
    total++;
    if (ACK_O !== 1'b0) $display("FAIL burst_early_ack: got %b want 0", ACK_O);
    else passed++;
    req(1'b1, 16'h400F, 16'hABCD); sb.push_back(16'h0);
    tick();
    total++;
    if (ACK_O !== 1'b1) $display("FAIL burst_ack1: got %b want 1", ACK_O);
    else passed++;
    STB_I = 1'b0;
    tick();
    total++;
    if (ACK_O !== 1'b1) $display("FAIL burst_ack2: got %b want 1", ACK_O);
    else passed++;
    total++;
    if (velocity !== 32'hABCD1234)
      $display("FAIL burst_vel: got %h want abcd1234", velocity);
    else passed++;
    total++;
    if ({velocity_valid, orphan_hi} !== 2'b10)
      $display("FAIL burst_valid_orphan: got %b want 10", {velocity_valid, orphan_hi});
    else passed++;
    tick();
    total++;
    if (velocity_valid !== 1'b0) $display("FAIL burst_valid_clr: got %b want 0", velocity_valid);
    else passed++;
    tick();
    CYC_I = 1'b0;
    total++;
    if (sb.size() != 0) $display("FAIL burst_missing_ack: got %0d pending want 0", sb.size());
    else passed++;
  endtask

  task automatic test_read();
    req(1'b0, 16'h400E, 16'h0); sb.push_back(16'h1234);
    tick();
    req(1'b0, 16'h400F, 16'h0); sb.push_back(16'hABCD);
    tick();
    req(1'b0, 16'h4010, 16'h0); sb.push_back(16'h0000);
    tick();
    STB_I = 1'b0;
    tick();
    tick();
    total++;
    if ({ACK_O, DAT_O} !== 17'h0)
      $display("FAIL read_idle: got ack=%b dat=%h want 0/0000", ACK_O, DAT_O);
    else passed++;
    CYC_I = 1'b0;
    total++;
    if (sb.size() != 0) $display("FAIL read_missing_ack: got %0d pending want 0", sb.size());
    else passed++;
  endtask

  task automatic test_backpressure();
    velocity_ready = 1'b0;
    req(1'b1, 16'h400E, 16'h1111); sb.push_back(16'h0);
    tick();
    req(1'b1, 16'h400F, 16'h2222); sb.push_back(16'h0);
    tick();
    STB_I = 1'b0;
    tick();
    total++;
    if ({velocity_valid, velocity} !== {1'b1, 32'h22221111})
      $display("FAIL bp_prefill: got %b/%h want 1/22221111", velocity_valid, velocity);
    else passed++;
    req(1'b1, 16'h400E, 16'h0001); sb.push_back(16'h0);
    tick();
    req(1'b1, 16'h400F, 16'h0002); sb.push_back(16'h0);
    tick();
    req(1'b1, 16'h4020, 16'h9999); sb.push_back(16'h0);
    tick();
    STB_I = 1'b0;
    total++;
    if (STALL_O !== 1'b1) $display("FAIL bp_stall_rise: got %b want 1", STALL_O);
    else passed++;
    tick();
    total++;
    if ({STALL_O, ACK_O} !== 2'b10)
      $display("FAIL bp_blocked: got stall/ack %b want 10", {STALL_O, ACK_O});
    else passed++;
    total++;
    if (velocity !== 32'h22221111) $display("FAIL bp_hold_vel: got %h want 22221111", velocity);
    else passed++;
    velocity_ready = 1'b1;
    tick();
    total++;
    if (velocity !== 32'h00020001) $display("FAIL bp_commit_vel: got %h want 00020001", velocity);
    else passed++;
    total++;
    if ({STALL_O, ACK_O, velocity_valid} !== 3'b011)
      $display("FAIL bp_release: got stall/ack/valid %b want 011",
               {STALL_O, ACK_O, velocity_valid});
    else passed++;
    tick();
    total++;
    if (velocity_valid !== 1'b0) $display("FAIL bp_valid_clr: got %b want 0", velocity_valid);
    else passed++;
    tick();
    CYC_I = 1'b0;
    total++;
    if (sb.size() != 0) $display("FAIL bp_missing_ack: got %0d pending want 0", sb.size());
    else passed++;
  endtask

  task automatic test_flush();
    velocity_ready = 1'b0;
    req(1'b1, 16'h400E, 16'h00AA); sb.push_back(16'h0);
    tick();
    req(1'b1, 16'h400F, 16'h00BB); sb.push_back(16'h0);
    tick();
    req(1'b1, 16'h400E, 16'h0CCC); sb.push_back(16'h0);
    tick();
    req(1'b1, 16'h400F, 16'h0DDD);
    tick();
    req(1'b1, 16'h400F, 16'h0EEE);
    tick();
    total++;
    if (STALL_O !== 1'b1) $display("FAIL flush_full: got %b want 1", STALL_O);
    else passed++;
    CYC_I = 1'b0;
    STB_I = 1'b0;
    tick();
    total++;
    if ({STALL_O, ACK_O, velocity_valid} !== 3'b001)
      $display("FAIL flush_state: got stall/ack/valid %b want 001",
               {STALL_O, ACK_O, velocity_valid});
    else passed++;
    total++;
    if (velocity !== 32'h00BB00AA) $display("FAIL flush_vel: got %h want 00bb00aa", velocity);
    else passed++;
    velocity_ready = 1'b1;
    req(1'b1, 16'h400F, 16'h0FFF); sb.push_back(16'h0);
    tick();
    STB_I = 1'b0;
    tick();
    total++;
    if ({velocity, orphan_hi} !== {32'h0FFF0CCC, 1'b0})
      $display("FAIL flush_lo_kept: got %h/%b want 0fff0ccc/0", velocity, orphan_hi);
    else passed++;
    tick();
    tick();
    CYC_I = 1'b0;
    total++;
    if (sb.size() != 0) $display("FAIL flush_missing_ack: got %0d pending want 0", sb.size());
    else passed++;
  endtask

  task automatic test_orphan();
    RST_I = 1'b0;
    tick();
    RST_I = 1'b1;
    tick();
    velocity_ready = 1'b1;
    req(1'b1, 16'h400F, 16'h5555); sb.push_back(16'h0);
    tick();
    STB_I = 1'b0;
    tick();
    total++;
    if ({velocity, velocity_valid, orphan_hi} !== {32'h55550000, 2'b11})
      $display("FAIL orphan_commit: got %h/%b/%b want 55550000/1/1",
               velocity, velocity_valid, orphan_hi);
    else passed++;
    tick();
    tick();
    CYC_I = 1'b0;
    total++;
    if (orphan_hi !== 1'b1) $display("FAIL orphan_sticky: got %b want 1", orphan_hi);
    else passed++;
    total++;
    if (sb.size() != 0) $display("FAIL orphan_missing_ack: got %0d pending want 0", sb.size());
    else passed++;
  endtask

  task automatic test_async_reset();
    velocity_ready = 1'b1;
    req(1'b1, 16'h400E, 16'h1357);
    tick();
    req(1'b1, 16'h400F, 16'h2468);
    tick();
    total++;
    if (ACK_O !== 1'b1) $display("FAIL arst_pre_ack: got %b want 1", ACK_O);
    else passed++;
    #1;
    RST_I = 1'b0;
    CYC_I = 1'b0;
    STB_I = 1'b0;
    #1;
    total++;
    if ({ACK_O, STALL_O, velocity_valid, orphan_hi, DAT_O, velocity} !== 52'h0)
      $display("FAIL arst_immediate: got ack=%b stall=%b valid=%b orphan=%b dat=%h vel=%h want all 0",
               ACK_O, STALL_O, velocity_valid, orphan_hi, DAT_O, velocity);
    else passed++;
    tick();
    tick();
    #2;
    RST_I = 1'b1;
    tick();
    tick();
    tick();
    total++;
    if (ACK_O !== 1'b0) $display("FAIL arst_no_ack: got %b want 0", ACK_O);
    else passed++;
    req(1'b0, 16'h400E, 16'h0); sb.push_back(16'h0);
    tick();
    STB_I = 1'b0;
    tick();
    total++;
    if ({ACK_O, DAT_O} !== 17'h10000)
      $display("FAIL arst_new_read: got ack=%b dat=%h want 1/0000", ACK_O, DAT_O);
    else passed++;
    tick();
    CYC_I = 1'b0;
    total++;
    if (sb.size() != 0) $display("FAIL arst_missing_ack: got %0d pending want 0", sb.size());
    else passed++;
  endtask

  initial begin
    test_reset();
    test_burst();
    test_read();
    test_backpressure();
    test_flush();
    test_orphan();
    test_async_reset();
    tick();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
